// File: rtl/latch_pkg.sv
// Shared constants for the gated SR latch slice.
package latch_pkg;
  // Resolution of S=R=1 while the gate is open.
  localparam int POLICY_NOR  = 0;  // both outputs low
  localparam int POLICY_HOLD = 1;  // keep the fed-back state
endpackage

// File: rtl/sr_latch_bit.sv
// One gated SR latch bit; state lives only in the external q/qp feedback.
module sr_latch_bit
  import latch_pkg::*;
#(
  parameter int POLICY = POLICY_NOR
) (
  input  logic gate,
  input  logic rst_n,
  input  logic s,
  input  logic r,
  input  logic q_fb,
  input  logic qp_fb,
  output logic q,
  output logic qp,
  output logic invalid,
  output logic inconsistent
);

  always_comb begin
    q            = q_fb;
    qp           = qp_fb;
    invalid      = 1'b0;
    inconsistent = 1'b0;
    if (!rst_n) begin
      q  = 1'b0;
      qp = 1'b1;
    end else begin
      inconsistent = (q_fb == qp_fb);
      // s/r are only looked at behind the gate, so unknowns on them stay out while closed
      if (gate) begin
        case ({s, r})
          2'b10: begin q = 1'b1; qp = 1'b0; end
          2'b01: begin q = 1'b0; qp = 1'b1; end
          2'b11: begin
            invalid = 1'b1;
            if (POLICY == POLICY_NOR) begin
              q  = 1'b0;
              qp = 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/latch_with_clock.sv
// WIDTH independent gated SR latch bits; purely combinational, zero latency.
module latch_with_clock
  import latch_pkg::*;
#(
  parameter int WIDTH          = 1,
  parameter int SR_BOTH_POLICY = POLICY_NOR
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic [WIDTH-1:0] S,
  input  logic [WIDTH-1:0] R,
  input  logic [WIDTH-1:0] inputQ,
  input  logic [WIDTH-1:0] inputQp,
  output logic [WIDTH-1:0] outputQ,
  output logic [WIDTH-1:0] outputQp,
  output logic [WIDTH-1:0] invalid,
  output logic [WIDTH-1:0] inconsistent
);

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    sr_latch_bit #(.POLICY(SR_BOTH_POLICY)) u_bit (
      .gate         (Clock),
      .rst_n        (Reset_n),
      .s            (S[gi]),
      .r            (R[gi]),
      .q_fb         (inputQ[gi]),
      .qp_fb        (inputQp[gi]),
      .q            (outputQ[gi]),
      .qp           (outputQp[gi]),
      .invalid      (invalid[gi]),
      .inconsistent (inconsistent[gi])
    );
  end

endmodule

// File: tb/tb_latch_with_clock.sv
// Table-driven bench for latch_with_clock, both S=R=1 policies side by side at WIDTH=4.
module tb_latch_with_clock;

  typedef struct {
    logic       rst_n;
    logic       g;
    logic [3:0] s, r, iq, iqp;
    logic [3:0] q0, qp0, inv0, inc0;  // expected, NOR policy
    logic [3:0] q1, qp1, inv1, inc1;  // expected, HOLD policy
    bit         fb;                   // 1: feedback from previous outputs
    int         id;
  } vec_t;

  logic       tclk;
  logic       gate, rst_n;
  logic [3:0] s, r;
  logic [3:0] iq0, iqp0, iq1, iqp1;
  logic [3:0] oq0, oqp0, inv0, inc0;
  logic [3:0] oq1, oqp1, inv1, inc1;

  int   checks   = 0;
  int   failures = 0;
  vec_t sb[$];
  vec_t e;

  latch_with_clock #(.WIDTH(4), .SR_BOTH_POLICY(0)) dut0 (
    .Clock(gate), .Reset_n(rst_n), .S(s), .R(r), .inputQ(iq0), .inputQp(iqp0),
    .outputQ(oq0), .outputQp(oqp0), .invalid(inv0), .inconsistent(inc0)
  );

  latch_with_clock #(.WIDTH(4), .SR_BOTH_POLICY(1)) dut1 (
    .Clock(gate), .Reset_n(rst_n), .S(s), .R(r), .inputQ(iq1), .inputQp(iqp1),
    .outputQ(oq1), .outputQp(oqp1), .invalid(inv1), .inconsistent(inc1)
  );

  initial tclk = 1'b0;
  always #5 tclk = ~tclk;

  task automatic chk(input string nm, input int id, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s vec%0d got=%h exp=%h", nm, id, got, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int id);
    @(posedge tclk);
    if (v.fb) begin
      iq0 = oq0; iqp0 = oqp0; iq1 = oq1; iqp1 = oqp1;
    end else begin
      iq0 = v.iq; iqp0 = v.iqp; iq1 = v.iq; iqp1 = v.iqp;
    end
    rst_n = v.rst_n; gate = v.g; s = v.s; r = v.r;
    v.id = id;
    sb.push_back(v);
  endtask

  always @(negedge tclk) begin
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("q_nor",    e.id, oq0,  e.q0);
      chk("qp_nor",   e.id, oqp0, e.qp0);
      chk("inv_nor",  e.id, inv0, e.inv0);
      chk("inc_nor",  e.id, inc0, e.inc0);
      chk("q_hold",   e.id, oq1,  e.q1);
      chk("qp_hold",  e.id, oqp1, e.qp1);
      chk("inv_hold", e.id, inv1, e.inv1);
      chk("inc_hold", e.id, inc1, e.inc1);
    end
  end

  vec_t vt[];
  vec_t sq[];

  initial begin
    gate = 0; rst_n = 0; s = 0; r = 0;
    iq0 = 0; iqp0 = 4'hf; iq1 = 0; iqp1 = 4'hf;

    // rst_n g   s     r     iq    iqp  | q0    qp0   inv0  inc0 | q1    qp1   inv1  inc1 | fb
    vt = '{
      '{1'b0, 1'b1, 4'hf, 4'h0, 4'h5, 4'h5, 4'h0, 4'hf, 4'h0, 4'h0, 4'h0, 4'hf, 4'h0, 4'h0, 1'b0, 0},
      '{1'b1, 1'b0, 4'hf, 4'hf, 4'h3, 4'hc, 4'h3, 4'hc, 4'h0, 4'h0, 4'h3, 4'hc, 4'h0, 4'h0, 1'b0, 0},
      '{1'b1, 1'b1, 4'h5, 4'ha, 4'h0, 4'hf, 4'h5, 4'ha, 4'h0, 4'h0, 4'h5, 4'ha, 4'h0, 4'h0, 1'b0, 0},
      '{1'b1, 1'b1, 4'h0, 4'h0, 4'h9, 4'h6, 4'h9, 4'h6, 4'h0, 4'h0, 4'h9, 4'h6, 4'h0, 4'h0, 1'b0, 0},
      '{1'b1, 1'b1, 4'hf, 4'hf, 4'ha, 4'h5, 4'h0, 4'h0, 4'hf, 4'h0, 4'ha, 4'h5, 4'hf, 4'h0, 1'b0, 0},
      '{1'b1, 1'b1, 4'h3, 4'h6, 4'h0, 4'hf, 4'h1, 4'hc, 4'h2, 4'h0, 4'h1, 4'he, 4'h2, 4'h0, 1'b0, 0},
      '{1'b1, 1'b0, 4'h0, 4'h0, 4'h4, 4'hf, 4'h4, 4'hf, 4'h0, 4'h4, 4'h4, 4'hf, 4'h0, 4'h4, 1'b0, 0},
      '{1'b0, 1'b0, 4'h0, 4'h0, 4'hf, 4'hf, 4'h0, 4'hf, 4'h0, 4'h0, 4'h0, 4'hf, 4'h0, 4'h0, 1'b0, 0},
      '{1'b1, 1'b0, 4'hf, 4'h0, 4'h0, 4'hf, 4'h0, 4'hf, 4'h0, 4'h0, 4'h0, 4'hf, 4'h0, 4'h0, 1'b0, 0},
      '{1'b1, 1'b1, 4'h0, 4'h0, 4'hf, 4'hf, 4'hf, 4'hf, 4'h0, 4'hf, 4'hf, 4'hf, 4'h0, 4'hf, 1'b0, 0}
    };

    // Feedback-tied sequences: reset release, closed gate, set/hold/reset/hold,
    // S=R=1 per policy, falling gate with R active, reset release into S=1.
    sq = '{
      '{1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 4'hf, 4'h0, 4'hf, 4'h0, 4'h0, 4'h0, 4'hf, 4'h0, 4'h0, 1'b0, 0},
      '{1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hf, 4'h0, 4'h0, 4'h0, 4'hf, 4'h0, 4'h0, 1'b1, 0},
      '{1'b1, 1'b0, 4'hf, 4'h0, 4'h0, 4'h0, 4'h0, 4'hf, 4'h0, 4'h0, 4'h0, 4'hf, 4'h0, 4'h0, 1'b1, 0},
      '{1'b1, 1'b0, 4'hf, 4'hf, 4'h0, 4'h0, 4'h0, 4'hf, 4'h0, 4'h0, 4'h0, 4'hf, 4'h0, 4'h0, 1'b1, 0},
      '{1'b1, 1'b1, 4'hf, 4'h0, 4'h0, 4'h0, 4'hf, 4'h0, 4'h0, 4'h0, 4'hf, 4'h0, 4'h0, 4'h0, 1'b1, 0},
      '{1'b1, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 4'hf, 4'h0, 4'h0, 4'h0, 4'hf, 4'h0, 4'h0, 4'h0, 1'b1, 0},
      '{1'b1, 1'b1, 4'h0, 4'hf, 4'h0, 4'h0, 4'h0, 4'hf, 4'h0, 4'h0, 4'h0, 4'hf, 4'h0, 4'h0, 1'b1, 0},
      '{1'b1, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hf, 4'h0, 4'h0, 4'h0, 4'hf, 4'h0, 4'h0, 1'b1, 0},
      '{1'b1, 1'b1, 4'hf, 4'h0, 4'h0, 4'h0, 4'hf, 4'h0, 4'h0, 4'h0, 4'hf, 4'h0, 4'h0, 4'h0, 1'b1, 0},
      '{1'b1, 1'b1, 4'hf, 4'hf, 4'h0, 4'h0, 4'h0, 4'h0, 4'hf, 4'h0, 4'hf, 4'h0, 4'hf, 4'h0, 1'b1, 0},
      '{1'b1, 1'b1, 4'h5, 4'ha, 4'h0, 4'h0, 4'h5, 4'ha, 4'h0, 4'hf, 4'h5, 4'ha, 4'h0, 4'h0, 1'b1, 0},
      '{1'b1, 1'b0, 4'h0, 4'hf, 4'h0, 4'h0, 4'h5, 4'ha, 4'h0, 4'h0, 4'h5, 4'ha, 4'h0, 4'h0, 1'b1, 0},
      '{1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h5, 4'ha, 4'h0, 4'h0, 4'h5, 4'ha, 4'h0, 4'h0, 1'b1, 0},
      '{1'b0, 1'b1, 4'hf, 4'h0, 4'h0, 4'h0, 4'h0, 4'hf, 4'h0, 4'h0, 4'h0, 4'hf, 4'h0, 4'h0, 1'b1, 0},
      '{1'b1, 1'b1, 4'hf, 4'h0, 4'h0, 4'h0, 4'hf, 4'h0, 4'h0, 4'h0, 4'hf, 4'h0, 4'h0, 4'h0, 1'b1, 0}
    };

    for (int i = 0; i < vt.size(); i++) apply(vt[i], i);
    for (int i = 0; i < sq.size(); i++) apply(sq[i], 100 + i);

    repeat (3) @(negedge tclk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d exp=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
